// File: rtl/axi_segment_decoder.sv
// axi_segment_decoder: registered base/mask address decoder for one bus segment.
// The granted master's address is decoded into a one-hot chip select, which is
// held for the whole transfer. An unmapped address, or more than one grant bit
// set, is routed to a built-in default-slave error responder instead.
// Optional feature macro: SEG_DECODE_ERR_CAPTURE_EN adds the ERR_ADDR capture port.

// One region comparator; one instance is built per slave.
module seg_region_match #(
  parameter logic [31:0] BASE = 32'h0,
  parameter logic [31:0] MASK = 32'h0
) (
  input  logic [31:0] addr,
  output logic        hit
);
  assign hit = ((addr & MASK) == (BASE & MASK));
endmodule

module axi_segment_decoder #(
  parameter int                     MASTERS   = 2,
  parameter int                     SLAVES    = 3,
  parameter logic [SLAVES*32-1:0]   BASE      = {32'h7000_0000, 32'h6060_0000, 32'h6000_0000},
  parameter logic [SLAVES*32-1:0]   MASK      = {3{32'hFFFF_0000}},
  parameter int                     ERR_CNT_W = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [MASTERS-1:0]   BUS_GRANTS,
  input  logic [31:0]          ADDR [MASTERS],
  input  logic                 ADDR_VALID,
  input  logic                 XFER_DONE,
  output logic [SLAVES-1:0]    CHIP_SELECTS,
  output logic                 SELECT_ERROR,
  output logic                 ERR_VALID,
  input  logic                 ERR_READY,
  output logic                 BUSY,
  output logic [ERR_CNT_W-1:0] ERR_COUNT
`ifdef SEG_DECODE_ERR_CAPTURE_EN
  ,
  output logic [31:0]          ERR_ADDR
`endif
);

  typedef enum logic [1:0] {IDLE, SEL, ERR} state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_mux;
  logic [SLAVES-1:0]   match;
  logic [SLAVES-1:0]   sel_oh;
  logic                any_hit;
  logic                multi_grant;
  logic                accept;
  logic                is_err;
  logic [SLAVES-1:0]   cs_q;
  logic                err_q;
  logic [ERR_CNT_W-1:0] cnt_q;

  // Address mux: OR of grant-gated addresses, so a zero grant yields 0.
  always_comb begin
    addr_mux = 32'h0;
    for (int m = 0; m < MASTERS; m++)
      if (BUS_GRANTS[m]) addr_mux = addr_mux | ADDR[m];
  end

  genvar gi;
  generate
    for (gi = 0; gi < SLAVES; gi++) begin : g_region
      seg_region_match #(
        .BASE (BASE[32*gi +: 32]),
        .MASK (MASK[32*gi +: 32])
      ) u_match (
        .addr (addr_mux),
        .hit  (match[gi])
      );
    end
  endgenerate

  // Overlapping regions resolve to the lowest index.
  always_comb begin
    sel_oh  = '0;
    any_hit = 1'b0;
    for (int i = 0; i < SLAVES; i++)
      if (match[i] && !any_hit) begin
        sel_oh[i] = 1'b1;
        any_hit   = 1'b1;
      end
  end

  assign multi_grant = (BUS_GRANTS & (BUS_GRANTS - 1'b1)) != '0;
  assign accept      = (state_q == IDLE) && ADDR_VALID && (BUS_GRANTS != '0);
  assign is_err      = multi_grant || !any_hit;

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: selection stays locked in SEL until XFER_DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_err ? ERR : SEL;
      SEL:     if (XFER_DONE) state_d = IDLE;
      ERR:     if (ERR_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered chip select and error-response flag.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cs_q  <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          cs_q  <= is_err ? '0 : sel_oh;
          err_q <= is_err;
        end
        SEL:  if (XFER_DONE) cs_q <= '0;
        ERR:  if (ERR_READY) err_q <= 1'b0;
        default: begin
          cs_q  <= '0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating decode-error counter.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                                cnt_q <= '0;
    else if (accept && is_err && (cnt_q != '1))  cnt_q <= cnt_q + 1'b1;
  end

`ifdef SEG_DECODE_ERR_CAPTURE_EN
  logic [31:0] err_addr_q;

  // Capture the offending address on each entry into ERR.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)              err_addr_q <= 32'h0;
    else if (accept && is_err) err_addr_q <= addr_mux;
  end

  assign ERR_ADDR = err_addr_q;
`endif

  assign CHIP_SELECTS = cs_q;
  assign SELECT_ERROR = err_q;
  assign ERR_VALID    = err_q;
  assign BUSY         = (state_q != IDLE);
  assign ERR_COUNT    = cnt_q;

endmodule

// File: doc/axi_segment_decoder.md
# axi_segment_decoder

Parametrised, registered address decoder for one bus segment. It replaces the fixed per-segment decoders with a single block configured by base/mask parameters. It muxes the granted master's address and holds a one-hot chip select for the whole transfer. Unmapped or illegal requests go to a built-in default-slave error responder with a valid/ready handshake and a saturating error counter. One instance sits between the segment arbiter and the segment's slaves.

## Interface
Parameters:
- MASTERS, 2, number of requesting masters (1..8)
- SLAVES, 3, number of decoded regions/slaves (1..32)
- BASE, {32'h7000_0000, 32'h6060_0000, 32'h6000_0000}, packed SLAVES×32 region bases, slave i at [32*i +: 32]
- MASK, {3{32'hFFFF_0000}}, packed SLAVES×32 compare masks, same layout
- ERR_CNT_W, 8, width of error counter

Ports:
- ACLK  in  1  clock, rising edge
- ARESETn  in  1  asynchronous active-low reset
- BUS_GRANTS  in  MASTERS  grant vector from arbiter, expected one-hot or zero
- ADDR  in  32 × MASTERS (unpacked)  per-master address
- ADDR_VALID  in  1  request level from granted master, held until accepted
- XFER_DONE  in  1  selected slave has completed the transfer
- CHIP_SELECTS  out  SLAVES  registered one-hot slave select
- SELECT_ERROR  out  1  registered, high while an error response is pending
- ERR_VALID  out  1  default-slave response valid
- ERR_READY  in  1  master accepts error response
- BUSY  out  1  decoder not in IDLE
- ERR_COUNT  out  ERR_CNT_W  saturating count of decode errors
- ERR_ADDR  out  32  address of most recent error (present only with SEG_DECODE_ERR_CAPTURE_EN)

## Operation
- Address mux: the address of the master whose grant bit is set. With a zero grant, the mux output is 32'h0.
- Match i: (addr & MASK[i]) == (BASE[i] & MASK[i]). Multiple matches resolve to the lowest index.
- Request accepted only in IDLE when ADDR_VALID=1 and BUS_GRANTS != 0. ADDR_VALID with zero grant is ignored.
- Error when no region matches, or when BUS_GRANTS has more than one bit set.
- FSM states: IDLE, SEL, ERR.
  - IDLE → SEL on an accepted request that matches. CHIP_SELECTS is loaded with the match one-hot.
  - IDLE → ERR on an accepted request that errors. SELECT_ERROR=1, ERR_VALID=1, ERR_COUNT increments.
  - SEL → IDLE on XFER_DONE. CHIP_SELECTS clears. Grant and address changes in SEL are ignored; the selection is locked.
  - ERR → IDLE on ERR_VALID & ERR_READY. SELECT_ERROR and ERR_VALID clear.
- BUSY = (state != IDLE).
- ERR_COUNT saturates at all-ones and never wraps.
- XFER_DONE outside SEL is ignored. ERR_READY outside ERR is ignored.

## Timing
- Reset (async assert, sync deassert by the system): state=IDLE. CHIP_SELECTS=0, SELECT_ERROR=0, ERR_VALID=0, BUSY=0, ERR_COUNT=0, ERR_ADDR=0. Reset mid-transfer drops selects immediately.
- Latency: request sampled at edge n. CHIP_SELECTS or ERR_VALID is high in the cycle after edge n (1 cycle).
- Return to IDLE at the edge sampling XFER_DONE or the ERR handshake. The next accepted request is sampled at the following edge, so the minimum spacing is 2 cycles per transfer.
- XFER_DONE together with a new ADDR_VALID at the same edge: the new request is not accepted. The master keeps ADDR_VALID high and it is accepted at the next edge.
- ERR_VALID stays high until ERR_READY; it is never withdrawn.
- Error in the same cycle the counter is at max: the response is still generated, and the count stays at max.

## Configuration
- SEG_DECODE_ERR_CAPTURE_EN defined: the ERR_ADDR port exists. It is loaded with the muxed address on every IDLE → ERR transition, holds until the next error, and resets to 0.
- Undefined: the ERR_ADDR port and register are absent. All other behaviour is identical.

## Test plan
- Reset then grant=2'b01, ADDR[0]=32'h6000_0010, ADDR_VALID → CHIP_SELECTS=3'b001 one cycle later, held 5 cycles until XFER_DONE, then 0 and BUSY=0.
- grant=2'b10, ADDR[1]=32'h7000_0004 → CHIP_SELECTS=3'b100. Changing grant/ADDR while in SEL leaves the select unchanged.
- ADDR=32'h9000_0000 → ERR_VALID=1, SELECT_ERROR=1, ERR_COUNT=1, ERR_ADDR=32'h9000_0000 (macro on). ERR_READY held low for 3 cycles, then high → all clear the cycle after the handshake.
- grant=2'b11 with a valid address → error path, ERR_COUNT increments, no chip select.
- ERR_CNT_W=2, five errors → ERR_COUNT sequence 1,2,3,3,3.
- ARESETn low in the middle of SEL → CHIP_SELECTS=0 and BUSY=0 without waiting for a clock edge. After release, a new request decodes normally.
